regs_dumper: RTL and testbench

Debug reader for the 32-entry integer register file. On a start pulse it walks a configurable index range through the register file's debug read port. Each register value is serialized as ASCII hex onto a byte stream with valid/ready handshake, which normally feeds the board UART transmitter. It sits beside the register file and the VGA register mapping, giving a text-channel view of the same architectural state.

---
 rtl/regs_dumper.sv | 165 ++++++++++++++++
 tb/tb_regs_dumper.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regs_dumper.sv
// Register-file debug dumper: walks START_IDX..END_IDX and streams each value as ASCII hex + EOL.
// Optional REGS_DUMP_NAME_EN adds an "xNN " name prefix to every line.
module regs_dumper #(
  parameter int          START_IDX = 0,
  parameter int          END_IDX   = 31,
  parameter bit          UPPERCASE = 1'b1,
  parameter logic [7:0]  EOL_CHAR  = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  Rd_addr,
  input  logic [31:0] Rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  // state   | meaning
  // IDLE    | waiting for start
  // LATCH   | capture Rd_data for the current index
  // PREFIX  | emit "xNN " (name build only)
  // HEX     | emit 8 hex digits, MSB nibble first
  // EOL     | emit line terminator, advance or finish
  // DONE    | one-cycle done pulse
`ifdef REGS_DUMP_NAME_EN
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_PREFIX, S_HEX, S_EOL, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_HEX, S_EOL, S_DONE} state_t;
`endif

  localparam logic [4:0] START_L = 5'(START_IDX);
  localparam logic [4:0] END_L   = 5'(END_IDX);
  // 'A'-10 or 'a'-10, so a nibble 10..15 adds straight onto it
  localparam logic [7:0] LETTER_OFS = UPPERCASE ? 8'h37 : 8'h57;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [31:0] r_shift, w_shift_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;
  logic        w_xfer;

  assign Rd_addr = r_idx;
  assign w_nib   = r_shift[31:28];
  assign w_hex   = (w_nib < 4'd10) ? {4'h3, w_nib} : (LETTER_OFS + {4'h0, w_nib});

`ifdef REGS_DUMP_NAME_EN
  logic [3:0] w_tens, w_ones;
  always_comb begin
    w_tens = 4'd0;
    w_ones = 4'(r_idx);
    if (r_idx >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(r_idx - 5'd30);
    end else if (r_idx >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(r_idx - 5'd20);
    end else if (r_idx >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(r_idx - 5'd10);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 5'd0;
      r_shift <= 32'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_LATCH;
          w_idx_nxt   = START_L;
        end
      end
      S_LATCH: begin
        w_shift_nxt = Rd_data;
        w_cnt_nxt   = 3'd0;
`ifdef REGS_DUMP_NAME_EN
        w_state_nxt = S_PREFIX;
`else
        w_state_nxt = S_HEX;
`endif
      end
`ifdef REGS_DUMP_NAME_EN
      S_PREFIX: begin
        tx_valid = 1'b1;
        w_xfer   = tx_ready;
        case (r_cnt[1:0])
          2'd0:    tx_data = 8'h78;
          2'd1:    tx_data = {4'h3, w_tens};
          2'd2:    tx_data = {4'h3, w_ones};
          default: tx_data = 8'h20;
        endcase
        if (w_xfer) begin
          if (r_cnt[1:0] == 2'd3) begin
            w_cnt_nxt   = 3'd0;
            w_state_nxt = S_HEX;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
`endif
      S_HEX: begin
        tx_valid = 1'b1;
        tx_data  = w_hex;
        w_xfer   = tx_ready;
        if (w_xfer) begin
          w_shift_nxt = {r_shift[27:0], 4'h0};
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) w_state_nxt = S_EOL;
        end
      end
      S_EOL: begin
        tx_valid = 1'b1;
        tx_data  = EOL_CHAR;
        w_xfer   = tx_ready;
        if (w_xfer) begin
          if (r_idx == END_L) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_state_nxt = S_LATCH;
          end
        end
      end
      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regs_dumper.sv
// Bench for regs_dumper: queue scoreboard on the byte stream plus table-driven single-register dumps.
// Three instances: x5 uppercase, x5 lowercase, full 0..31 uppercase.
module tb_regs_dumper;

`ifdef REGS_DUMP_NAME_EN
  localparam int LINE = 13;
`else
  localparam int LINE = 9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tx_ready = 1'b1;
  logic [1:0] sel = 2'd0;
  always #5 clk = ~clk;

  logic [31:0] regs [32];
  logic [2:0][4:0]  rd_addr;
  logic [2:0][31:0] rd_data;
  logic [2:0][7:0]  txd;
  logic [2:0]       txv, bsy, dn, st;

  for (genvar g = 0; g < 3; g++) begin : g_rf
    assign rd_data[g] = (rd_addr[g] == 5'd0) ? 32'd0 : regs[rd_addr[g]];
    assign st[g]      = start && (sel == 2'(g));
  end

  regs_dumper #(.START_IDX(5), .END_IDX(5), .UPPERCASE(1'b1)) u_up (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .Rd_addr(rd_addr[0]), .Rd_data(rd_data[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready), .busy(bsy[0]), .done(dn[0]));
  regs_dumper #(.START_IDX(5), .END_IDX(5), .UPPERCASE(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .Rd_addr(rd_addr[1]), .Rd_data(rd_data[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready), .busy(bsy[1]), .done(dn[1]));
  regs_dumper u_full (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .Rd_addr(rd_addr[2]), .Rd_data(rd_data[2]),
    .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(tx_ready), .busy(bsy[2]), .done(dn[2]));

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  logic [7:0] q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit upper);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (upper ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_line(input int idx, input bit upper);
    logic [31:0] v;
    v = (idx == 0) ? 32'd0 : regs[idx];
`ifdef REGS_DUMP_NAME_EN
    q.push_back(8'h78);
    q.push_back(8'(8'h30 + idx / 10));
    q.push_back(8'(8'h30 + idx % 10));
    q.push_back(8'h20);
`endif
    for (int i = 7; i >= 0; i--) q.push_back(hexc(v[i*4 +: 4], upper));
    q.push_back(8'h0A);
  endtask

  // Byte monitor: every accepted byte must match the scoreboard head; stalled bytes must hold.
  logic stalled = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        chk("hold_valid", 32'(txv[sel]), 32'd1);
        chk("hold_data", 32'(txd[sel]), 32'(stall_data));
      end
      if (txv[sel] && tx_ready) begin
        n_xfer++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", txd[sel]);
        end else begin
          chk("byte", 32'(txd[sel]), 32'(q.pop_front()));
        end
      end
      stalled = txv[sel] && !tx_ready;
      stall_data = txd[sel];
    end else begin
      stalled = 1'b0;
    end
  end

  // Cycle 0 carries the start pulse; cycle k follows clock edge k-1.
  task automatic run(input logic [1:0] inst, input int ncyc, input int restart_cyc,
                     input int stall_lo, input int stall_n, input int rst_cyc,
                     output int done_cyc, output int done_cnt, output logic busy_at_done);
    sel = inst;
    done_cyc = -1;
    done_cnt = 0;
    busy_at_done = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    tx_ready = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      if (dn[sel]) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = bsy[sel];
        end
      end
      start = (cyc == restart_cyc);
      tx_ready = !(cyc >= stall_lo && cyc < stall_lo + stall_n);
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(txv[sel]), 32'd0);
        chk("rst_busy", 32'(bsy[sel]), 32'd0);
        chk("rst_addr", 32'(rd_addr[sel]), 32'd0);
      end else begin
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    tx_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  inst;
    logic [31:0] val;
    int          restart_cyc;
    int          stall_lo;
    int          stall_n;
    int          exp_done;
  } vec_t;

  vec_t vecs [7];
  int dc, dcnt;
  logic bad;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);

    vecs[0] = '{2'd0, 32'hDEADBEEF, -1, -1, 0, LINE + 2};
    vecs[1] = '{2'd1, 32'h00C0FFEE, -1, -1, 0, LINE + 2};
    vecs[2] = '{2'd0, 32'h01234567, -1, -1, 0, LINE + 2};
    vecs[3] = '{2'd1, 32'h89ABCDEF, -1, -1, 0, LINE + 2};
    vecs[4] = '{2'd0, 32'hDEADBEEF, -1, LINE - 5, 2, LINE + 4};
    vecs[5] = '{2'd1, 32'hFFFFFFFF,  4, -1, 0, LINE + 2};
    vecs[6] = '{2'd0, 32'h00000000, -1, 2, 3, LINE + 5};

    #12;
    chk("reset_valid", 32'(txv[0]), 32'd0);
    chk("reset_busy", 32'(bsy[0]), 32'd0);
    chk("reset_done", 32'(dn[0]), 32'd0);
    chk("reset_data", 32'(txd[0]), 32'd0);
    chk("reset_addr", 32'(rd_addr[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      regs[5] = vecs[v].val;
      push_line(5, vecs[v].inst == 2'd0);
      n_xfer = 0;
      run(vecs[v].inst, LINE + 10, vecs[v].restart_cyc, vecs[v].stall_lo, vecs[v].stall_n, -1,
          dc, dcnt, bad);
      chk($sformatf("v%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_done_count", v), 32'(dcnt), 32'd1);
      chk($sformatf("v%0d_busy_at_done", v), 32'(bad), 32'd0);
      chk($sformatf("v%0d_xfers", v), 32'(n_xfer), 32'(LINE));
      chk($sformatf("v%0d_queue_left", v), 32'(q.size()), 32'd0);
      chk($sformatf("v%0d_busy_end", v), 32'(bsy[vecs[v].inst]), 32'd0);
      q.delete();
    end

    // Reset in cycle 6 of an x5 dump: four bytes out, then nothing.
    regs[5] = 32'hDEADBEEF;
    push_line(5, 1'b1);
    n_xfer = 0;
    run(2'd0, 12, -1, -1, 0, 6, dc, dcnt, bad);
    chk("rst_done_count", 32'(dcnt), 32'd0);
    chk("rst_xfers", 32'(n_xfer), 32'd4);
    chk("rst_queue_left", 32'(q.size()), 32'(LINE - 4));
    q.delete();
    push_line(5, 1'b1);
    n_xfer = 0;
    run(2'd0, LINE + 6, -1, -1, 0, -1, dc, dcnt, bad);
    chk("post_rst_done_cycle", 32'(dc), 32'(LINE + 2));
    chk("post_rst_xfers", 32'(n_xfer), 32'(LINE));
    chk("post_rst_queue_left", 32'(q.size()), 32'd0);
    q.delete();

    // Full 0..31 dump, register i holds i (x0 forced to zero by the read port).
    regs[0] = 32'hFFFFFFFF;
    regs[5] = 32'd5;
    for (int i = 0; i < 32; i++) push_line(i, 1'b1);
    n_xfer = 0;
    run(2'd2, 32 * (LINE + 1) + 6, -1, -1, 0, -1, dc, dcnt, bad);
    chk("full_done_cycle", 32'(dc), 32'(32 * (LINE + 1) + 1));
    chk("full_done_count", 32'(dcnt), 32'd1);
    chk("full_xfers", 32'(n_xfer), 32'(32 * LINE));
    chk("full_queue_left", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
